// File: rtl/bus_initiator.sv
// -----------------------------------------------------------------------------
// bus_initiator
//   Master-side engine for the single-cycle-select peripheral slave bus.
//   One request at a time is taken from a valid/ready client port and is run
//   as one slave access. The result comes back on a valid/ready response port.
//   Misaligned addresses are refused without touching the bus. An access
//   counter stops a dead slave from hanging the client.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   req_*             client request (valid/ready, write, addr, wdata)
//   rsp_*             client response (valid/ready, rdata, err)
//   bus_ss/bus_wr     slave select and write qualifier (registered)
//   bus_addr/bus_wdata access address and write data (registered)
//   bus_rdata/bus_bdone slave read data and done strobe
//   busy              engine is not idle
// -----------------------------------------------------------------------------
module bus_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // 0 = wait for bus_bdone forever
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_ss,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_bdone,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_ss_q, bus_ss_d;
  logic                bus_wr_q, bus_wr_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic misaligned;
  logic timeout_hit;

  assign misaligned = |req_addr[1:0];

  // The count lags the access by one. Ending the access when the count
  // reads TIMEOUT-1 therefore keeps bus_ss high for exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_ss_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_ss_q    <= bus_ss_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default first on every comb-assigned signal prevents latches.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = misaligned ? S_RESP : S_ACCESS;
      S_ACCESS: if (bus_bdone || timeout_hit) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    bus_ss_d    = bus_ss_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            // Refused before reaching the bus. bus_addr keeps its last value.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            bus_ss_d    = 1'b1;
            bus_wr_d    = req_write;
            bus_addr_d  = req_addr;
            bus_wdata_d = req_wdata;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // bus_bdone is checked first, so it wins when it lands on the
        // timeout edge.
        if (bus_bdone) begin
          bus_ss_d    = 1'b0;
          bus_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus_wr_q ? '0 : bus_rdata;
        end else if (timeout_hit) begin
          bus_ss_d    = 1'b0;
          bus_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign bus_ss    = bus_ss_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_bus_initiator
//   Directed bench for bus_initiator. It uses a slave model with a settable
//   wait count, a stuck-done mode and a single write-capture register.
//   Expected values are worked out by hand from the bus protocol.
// -----------------------------------------------------------------------------
module tb_bus_initiator;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              bus_ss;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_bdone;
  logic              busy;

  always #5 clk = ~clk;

  bus_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_ss    (bus_ss),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_bdone (bus_bdone),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Slave model and bus monitor
  // ---------------------------------------------------------------------------
  int          wait_cfg  = 0;
  bit          stuck     = 1'b0;
  logic [31:0] rdata_cfg = '0;
  logic [31:0] addr_ref  = '0;
  int          wcnt      = 0;
  int          ss_cycles = 0;
  int          wr_cycles = 0;
  int          addr_bad  = 0;
  int          rsp_seen  = 0;
  logic [31:0] model_reg = '0;

  assign bus_bdone = bus_ss && !stuck && (wcnt == wait_cfg);
  assign bus_rdata = rdata_cfg;

  always @(posedge clk) begin
    if (bus_ss && !bus_bdone) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
    if (bus_ss)                       ss_cycles <= ss_cycles + 1;
    if (bus_ss && bus_wr)             wr_cycles <= wr_cycles + 1;
    if (bus_ss && bus_wr && bus_bdone) model_reg <= bus_wdata;
    if (bus_ss && bus_addr != addr_ref) addr_bad <= addr_bad + 1;
    if (rsp_valid)                    rsp_seen  <= rsp_seen + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request. lat is the number of falling edges from the accept
  // edge up to the first one that shows rsp_valid.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_arrived", rsp_valid, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", rsp_valid, 0);
    check("idle_after_rsp", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, ss0, wr0, bad0, seen0;
  logic [31:0] reg_before;

  initial begin
    // Reset state
    #12;
    check("rst_bus_ss", bus_ss, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-wait write of 0xA5 to 0x0C
    wait_cfg = 0; addr_ref = 32'h0C;
    ss0 = ss_cycles; wr0 = wr_cycles; bad0 = addr_bad;
    issue(1'b1, 32'h0000_000C, 32'h0000_00A5, lat);
    check("wr_latency", lat, 2);
    check("wr_ss_cycles", ss_cycles - ss0, 1);
    check("wr_wr_cycles", wr_cycles - wr0, 1);
    check("wr_err", rsp_err, 0);
    check("wr_rdata", rsp_rdata, 0);
    check("wr_model_reg", model_reg, 32'hA5);
    check("wr_ss_low", bus_ss, 0);
    check("wr_wr_low", bus_wr, 0);
    handshake();

    // 2: read 0x04 with 3 wait cycles
    wait_cfg = 3; rdata_cfg = 32'h0000_003C; addr_ref = 32'h04;
    ss0 = ss_cycles; bad0 = addr_bad;
    issue(1'b0, 32'h0000_0004, 32'h0, lat);
    check("rd3_latency", lat, 5);
    check("rd3_ss_cycles", ss_cycles - ss0, 4);
    check("rd3_addr_stable", addr_bad - bad0, 0);
    check("rd3_rdata", rsp_rdata, 32'h3C);
    check("rd3_err", rsp_err, 0);
    check("rd3_addr_kept", bus_addr, 32'h04);
    handshake();

    // 3: timeout on a stuck slave, then a normal read
    stuck = 1'b1; rdata_cfg = 32'hDEAD_BEEF; addr_ref = 32'h10;
    ss0 = ss_cycles;
    issue(1'b0, 32'h0000_0010, 32'h0, lat);
    check("to_latency", lat, 17);
    check("to_ss_cycles", ss_cycles - ss0, 16);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);
    handshake();
    stuck = 1'b0; wait_cfg = 0; rdata_cfg = 32'h1234_5678; addr_ref = 32'h08;
    issue(1'b0, 32'h0000_0008, 32'h0, lat);
    check("post_to_latency", lat, 2);
    check("post_to_rdata", rsp_rdata, 32'h1234_5678);
    check("post_to_err", rsp_err, 0);
    handshake();

    // 4: misaligned request to 0x06
    ss0 = ss_cycles;
    issue(1'b0, 32'h0000_0006, 32'h0, lat);
    check("mis_latency", lat, 1);
    check("mis_ss_cycles", ss_cycles - ss0, 0);
    check("mis_err", rsp_err, 1);
    check("mis_rdata", rsp_rdata, 0);
    handshake();

    // 5: response back-pressure with a competing request pending
    wait_cfg = 1; rdata_cfg = 32'h0000_55AA; addr_ref = 32'h14;
    issue(1'b0, 32'h0000_0014, 32'h0, lat);
    check("bp_latency", lat, 3);
    ss0 = ss_cycles;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h18; req_wdata = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h55AA);
      check("bp_rsp_err", rsp_err, 0);
      check("bp_req_ready", req_ready, 0);
    end
    check("bp_no_accept", ss_cycles - ss0, 0);
    req_valid = 1'b0;
    handshake();

    // 6: reset during a wait-stated write, then a fresh read
    wait_cfg = 10; addr_ref = 32'h20;
    reg_before = model_reg;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_ss_before", bus_ss, 1);
    check("rst_mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ss_async", bus_ss, 0);
    check("rst_mid_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen0 = rsp_seen;
    repeat (6) @(negedge clk);
    check("rst_mid_no_rsp", rsp_seen - seen0, 0);
    check("rst_mid_no_write", model_reg, reg_before);
    wait_cfg = 2; rdata_cfg = 32'h0000_0099; addr_ref = 32'h24;
    issue(1'b0, 32'h0000_0024, 32'h0, lat);
    check("rst_fresh_latency", lat, 4);
    check("rst_fresh_rdata", rsp_rdata, 32'h99);
    check("rst_fresh_err", rsp_err, 0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
